// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and sizing for the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

  localparam int FQ_DEPTH     = 2;
  localparam int FQ_PTR_W     = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int FQ_CNT_W     = $clog2(FQ_DEPTH + 1);
  localparam int FETCH_INST_W = 32;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0]             pc;
    logic [FETCH_INST_W-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_if
// Description : Backend, icache and decode handshake bundle of the fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) ();

  logic                  fetch_en;
  logic                  redirect_valid;
  logic [31:0]           redirect_pc;
  logic                  icache_req;
  logic [ADDR_WIDTH-1:0] icache_addr;
  logic [DATA_WIDTH-1:0] icache_rdata;
  logic                  valid_o;
  logic                  ready_i;
  logic [31:0]           pc_o;
  logic [DATA_WIDTH-1:0] inst_o;

  // Fetch controller side.
  modport master (
    input  fetch_en,
    input  redirect_valid,
    input  redirect_pc,
    input  icache_rdata,
    input  ready_i,
    output icache_req,
    output icache_addr,
    output valid_o,
    output pc_o,
    output inst_o
  );

  // Environment side: backend, icache and decode.
  modport slave (
    output fetch_en,
    output redirect_valid,
    output redirect_pc,
    output icache_rdata,
    output ready_i,
    input  icache_req,
    input  icache_addr,
    input  valid_o,
    input  pc_o,
    input  inst_o
  );

endinterface
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small FIFO of fetched {pc, inst} entries with synchronous flush.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
  import fetch_pkg::*;
(
  input  logic                clk,
  input  logic                reset_n,
  input  logic                push_i,
  input  fetch_entry_t        push_entry_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic [FQ_CNT_W-1:0] count_o,
  output fetch_entry_t        head_o
);

  logic [FQ_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [FQ_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [FQ_CNT_W-1:0] count_q,  count_d;
  fetch_entry_t        mem_q [FQ_DEPTH];

  function automatic logic [FQ_PTR_W-1:0] ptr_inc(input logic [FQ_PTR_W-1:0] ptr);
    if (ptr == FQ_PTR_W'(FQ_DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  // The caller guarantees no push into a full queue and no pop from an empty one.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < FQ_DEPTH; i++) begin
        if (push_i && !flush_i && (wr_ptr_q == FQ_PTR_W'(i))) begin
          mem_q[i] <= push_entry_i;
        end
      end
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction fetch controller: icache request sequencing,
//               redirect/flush handling and a 2-entry decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 9,
  parameter int          DATA_WIDTH = 32,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic    clk,
  input  logic    reset_n,
  fetch_if.master bus
);

  fetch_state_e        state_q,    state_d;
  logic [31:0]         pc_req_q,   pc_req_d;
  logic                inflight_q, inflight_d;
  logic [31:0]         tag_q,      tag_d;

  logic [FQ_CNT_W-1:0] count;
  fetch_entry_t        head;
  fetch_entry_t        push_entry;
  logic                valid;
  logic                pop;
  logic                push;
  logic                issue;
  logic [FQ_CNT_W:0]   occ;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.fetch_en)  state_d = RUN;
      RUN:     if (!bus.fetch_en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // occ counts queued entries plus the outstanding response, net of this
  // cycle's pop; keeping it below the depth reserves a slot for every response.
  always_comb begin
    valid = (count != '0) && !bus.redirect_valid;
    pop   = valid && bus.ready_i;
    occ   = {1'b0, count} + (FQ_CNT_W + 1)'(inflight_q) - (FQ_CNT_W + 1)'(pop);
    issue = (state_q == RUN) && bus.fetch_en && !bus.redirect_valid
            && (occ < (FQ_CNT_W + 1)'(FQ_DEPTH));
    push  = inflight_q && !bus.redirect_valid;
  end

  always_comb begin
    pc_req_d   = pc_req_q;
    inflight_d = issue;
    tag_d      = tag_q;
    if (bus.redirect_valid) begin
      pc_req_d = bus.redirect_pc & ~32'd3;
    end else if (issue) begin
      pc_req_d = pc_req_q + 32'd4;
      tag_d    = pc_req_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      pc_req_q   <= RESET_PC;
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      state_q    <= state_d;
      pc_req_q   <= pc_req_d;
      inflight_q <= inflight_d;
      tag_q      <= tag_d;
    end
  end

  always_comb begin
    push_entry      = '0;
    push_entry.pc   = tag_q;
    push_entry.inst = FETCH_INST_W'(bus.icache_rdata);
  end

  fetch_queue u_queue (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .flush_i      (bus.redirect_valid),
    .count_o      (count),
    .head_o       (head)
  );

  assign bus.icache_req  = issue;
  assign bus.icache_addr = pc_req_q[ADDR_WIDTH+1:2];
  assign bus.valid_o     = valid;
  assign bus.pc_o        = head.pc;
  assign bus.inst_o      = DATA_WIDTH'(head.inst);

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl: vector table plus scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;
  import fetch_pkg::*;

  localparam int          AW  = 9;
  localparam int          DW  = 32;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          NV  = 19;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  fetch_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (RPC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // icache model: word n of memory holds the value n.
  always @(posedge clk) bus.icache_rdata <= {{(DW-AW){1'b0}}, bus.icache_addr};

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return {{(32-AW){1'b0}}, pc[AW+1:2]};
  endfunction

  task automatic drive(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc);
    bus.fetch_en       = fe;
    bus.ready_i        = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  // Scoreboard: PCs of issued requests, popped when decode accepts the head.
  logic [31:0] sbq[$];
  logic [31:0] model_pc;
  bit          model_run;
  bit          mon_en = 1'b0;
  bit          m_pop;
  bit          m_req;
  int          m_occ;
  logic [31:0] m_head;

  always @(negedge clk) begin
    if (mon_en) begin
      m_pop = bus.valid_o && bus.ready_i;
      if (bus.redirect_valid) begin
        chk("mon_redirect_valid", bus.valid_o, 1'b0);
        chk("mon_redirect_req", bus.icache_req, 1'b0);
        sbq.delete();
        model_pc = bus.redirect_pc & ~32'd3;
      end else begin
        m_occ = sbq.size() - (m_pop ? 1 : 0);
        m_req = model_run && bus.fetch_en && (m_occ < 2);
        chk("mon_req", bus.icache_req, m_req);
        if (bus.valid_o) begin
          if (sbq.size() == 0) begin
            chk("mon_unexpected_valid", bus.valid_o, 1'b0);
          end else begin
            m_head = sbq[0];
            chk("mon_pc", bus.pc_o, m_head);
            chk("mon_inst", bus.inst_o, mem_word(m_head));
            if (bus.ready_i) void'(sbq.pop_front());
          end
        end
        if (bus.icache_req) begin
          chk("mon_addr", bus.icache_addr, model_pc[AW+1:2]);
          sbq.push_back(model_pc);
          model_pc = model_pc + 32'd4;
        end
        chk("mon_occupancy_le2", sbq.size() <= 2, 1'b1);
      end
      model_run = bus.fetch_en;
    end
  end

  typedef struct {
    bit          fe;
    bit          rdy;
    bit          rv;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          vld;
    logic [31:0] pc;
    logic [31:0] inst;
  } vec_t;

  vec_t vecs [NV];

  function automatic vec_t mk(input bit fe, input bit rdy, input bit rv, input logic [31:0] rpc,
                              input bit req, input logic [31:0] addr,
                              input bit vld, input logic [31:0] pc, input logic [31:0] inst);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.req = req; v.addr = addr; v.vld = vld; v.pc = pc; v.inst = inst;
    return v;
  endfunction

  task automatic release_reset();
    @(posedge clk); #1;
    sbq.delete();
    model_pc  = RPC;
    model_run = 1'b0;
    reset_n   = 1'b1;
    mon_en    = 1'b1;
  endtask

  logic [31:0] got_pc [3];
  int          n_got;
  int          n_req;
  int          n_pop;
  logic [31:0] last_pc;
  bit          found;

  initial begin
    // Startup stream, 5-cycle decode stall, then redirect to 0x103.
    vecs[0]  = mk(1, 1, 0, 0, 0, 0,     0, 0,     0);
    vecs[1]  = mk(1, 1, 0, 0, 1, 0,     0, 0,     0);
    vecs[2]  = mk(1, 1, 0, 0, 1, 1,     0, 0,     0);
    vecs[3]  = mk(1, 1, 0, 0, 1, 2,     1, 32'h0, 0);
    vecs[4]  = mk(1, 1, 0, 0, 1, 3,     1, 32'h4, 1);
    vecs[5]  = mk(1, 1, 0, 0, 1, 4,     1, 32'h8, 2);
    for (int i = 6; i <= 10; i++) vecs[i] = mk(1, 0, 0, 0, 0, 0, 1, 32'hC, 3);
    vecs[11] = mk(1, 1, 0, 0, 1, 5,     1, 32'hC, 3);
    vecs[12] = mk(1, 1, 0, 0, 1, 6,     1, 32'h10, 4);
    vecs[13] = mk(1, 1, 0, 0, 1, 7,     1, 32'h14, 5);
    vecs[14] = mk(1, 1, 0, 0, 1, 8,     1, 32'h18, 6);
    vecs[15] = mk(1, 1, 1, 32'h103, 0, 0, 0, 0,    0);
    vecs[16] = mk(1, 1, 0, 0, 1, 32'h40, 0, 0,     0);
    vecs[17] = mk(1, 1, 0, 0, 1, 32'h41, 0, 0,     0);
    vecs[18] = mk(1, 1, 0, 0, 1, 32'h42, 1, 32'h100, 32'h40);

    drive(0, 0, 0, 32'h0);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_icache_req", bus.icache_req, 1'b0);
    chk("reset_icache_addr", bus.icache_addr, RPC[AW+1:2]);
    chk("reset_valid_o", bus.valid_o, 1'b0);
    chk("reset_pc_o", bus.pc_o, 32'h0);
    chk("reset_inst_o", bus.inst_o, 32'h0);
    @(posedge clk);
    release_reset();

    for (int i = 0; i < NV; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].fe, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(negedge clk);
      chk($sformatf("vec%0d_req", i), bus.icache_req, vecs[i].req);
      chk($sformatf("vec%0d_valid", i), bus.valid_o, vecs[i].vld);
      if (vecs[i].req) chk($sformatf("vec%0d_addr", i), bus.icache_addr, vecs[i].addr[AW-1:0]);
      if (vecs[i].vld) begin
        chk($sformatf("vec%0d_pc", i), bus.pc_o, vecs[i].pc);
        chk($sformatf("vec%0d_inst", i), bus.inst_o, vecs[i].inst);
      end
    end

    // PC wrap across the top of the address space.
    @(posedge clk); #1;
    drive(1, 1, 1, 32'hFFFF_FFF8);
    n_got = 0;
    for (int c = 0; c < 20 && n_got < 3; c++) begin
      @(posedge clk); #1;
      drive(1, 1, 0, 32'h0);
      @(negedge clk);
      if (bus.valid_o) begin
        got_pc[n_got] = bus.pc_o;
        n_got++;
      end
    end
    chk("wrap_pop_count", n_got, 3);
    if (n_got == 3) begin
      chk("wrap_pc0", got_pc[0], 32'hFFFF_FFF8);
      chk("wrap_pc1", got_pc[1], 32'hFFFF_FFFC);
      chk("wrap_pc2", got_pc[2], 32'h0000_0000);
    end

    // fetch_en dropped in the cycle after a request.
    @(posedge clk); #1;
    drive(1, 1, 1, 32'h200);
    @(posedge clk); #1;
    drive(1, 1, 0, 32'h0);
    @(negedge clk);
    chk("drop_first_req", bus.icache_req, 1'b1);
    chk("drop_first_addr", bus.icache_addr, 9'h080);
    n_req = 0;
    n_pop = 0;
    last_pc = '0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      drive(0, 1, 0, 32'h0);
      @(negedge clk);
      if (bus.icache_req) n_req++;
      if (bus.valid_o) begin
        n_pop++;
        last_pc = bus.pc_o;
      end
    end
    chk("drop_no_requests", n_req, 0);
    chk("drop_one_response", n_pop, 1);
    chk("drop_response_pc", last_pc, 32'h200);
    chk("drop_drained", bus.valid_o, 1'b0);

    // Asynchronous reset mid-stream.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      drive(1, 1, 0, 32'h0);
    end
    @(negedge clk);
    mon_en = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    chk("areset_icache_req", bus.icache_req, 1'b0);
    chk("areset_icache_addr", bus.icache_addr, RPC[AW+1:2]);
    chk("areset_valid_o", bus.valid_o, 1'b0);
    chk("areset_pc_o", bus.pc_o, 32'h0);
    chk("areset_inst_o", bus.inst_o, 32'h0);
    @(posedge clk);
    @(posedge clk);
    release_reset();
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.valid_o) begin
        found = 1'b1;
        chk("areset_first_pc", bus.pc_o, RPC);
        chk("areset_first_inst", bus.inst_o, mem_word(RPC));
      end
    end
    chk("areset_first_valid_seen", found, 1'b1);

    @(posedge clk); #1;
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
